// File: rtl/inst_dispatch.sv
// inst_dispatch: fetches instructions, decodes them and sequences the load and convolution engines
module inst_dispatch #(
  parameter int LD_ADDR_W = 12,
  parameter int LD_LEN_W = 16,
  parameter logic [3:0] OP_LF = 4'h1,
  parameter logic [3:0] OP_LI = 4'h2,
  parameter logic [3:0] OP_LS = 4'h3,
  parameter logic [3:0] OP_DC = 4'h4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 fifo_r_en,
  input  logic                 fifo_r_accept,
  input  logic [31:0]          fifo_inst,
  output logic                 ld_start,
  output logic                 ld_sel,
  output logic [LD_ADDR_W-1:0] ld_addr,
  output logic [LD_LEN_W-1:0]  ld_len,
  input  logic                 ld_done,
  output logic                 conv_start,
  output logic [3:0]           conv_stride,
  output logic [LD_LEN_W-1:0]  conv_out_addr,
  input  logic                 conv_done,
  output logic                 busy,
  output logic [15:0]          inst_count,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE_LD, WAIT_LD, ISSUE_CONV, WAIT_CONV} state_t;
  state_t state, state_nx;
  logic [31:0] inst;
  logic [3:0] op;
  logic is_ld, is_dc, is_ls_ok, retire;
  assign op = inst[31:28];
  assign is_ld = op == OP_LF || op == OP_LI;
  assign is_dc = op == OP_DC;
  assign is_ls_ok = op == OP_LS && inst[3:0] != 4'h0;
  assign fifo_r_en = state == FETCH;
  assign ld_start = state == ISSUE_LD;
  assign conv_start = state == ISSUE_CONV;
  assign busy = state != IDLE;
  // next state; done inputs only matter in their own wait state
  always_comb begin
    state_nx = state;
    retire = 1'b0;
    case (state)
      IDLE: state_nx = run ? FETCH : IDLE;
      FETCH: state_nx = fifo_r_accept ? DECODE : run ? FETCH : IDLE;
      DECODE: begin
        retire = !is_ld && !is_dc;
        state_nx = is_ld ? ISSUE_LD : is_dc ? ISSUE_CONV : run ? FETCH : IDLE;
      end
      ISSUE_LD: state_nx = WAIT_LD;
      WAIT_LD: begin
        retire = ld_done;
        state_nx = ld_done ? (run ? FETCH : IDLE) : WAIT_LD;
      end
      ISSUE_CONV: state_nx = WAIT_CONV;
      WAIT_CONV: begin
        retire = conv_done;
        state_nx = conv_done ? (run ? FETCH : IDLE) : WAIT_CONV;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // instruction register, cleared on reset so a half-run instruction is discarded
  always_ff @(posedge clk or posedge rst)
    if (rst) inst <= '0;
    else if (state == FETCH && fifo_r_accept) inst <= fifo_inst;
  // load command fields, held until the next load decode
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_sel <= 1'b0;
      ld_addr <= '0;
      ld_len <= '0;
    end else if (state == DECODE && is_ld) begin
      ld_sel <= op == OP_LI;
      ld_addr <= inst[16 +: LD_ADDR_W];
      ld_len <= inst[LD_LEN_W-1:0];
    end
  // convolution configuration and sticky error for bad stride or unknown opcode
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      conv_stride <= 4'd1;
      conv_out_addr <= '0;
      err <= 1'b0;
    end else if (state == DECODE) begin
      if (is_dc) conv_out_addr <= inst[LD_LEN_W-1:0];
      if (is_ls_ok) conv_stride <= inst[3:0];
      if (!is_ld && !is_dc && !is_ls_ok) err <= 1'b1;
    end
  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst)
    if (rst) inst_count <= '0;
    else if (retire) inst_count <= inst_count + 16'd1;
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: directed and randomized checks of inst_dispatch against an instruction-level model
module tb_inst_dispatch;
  localparam logic [3:0] OP_LF = 4'h1, OP_LI = 4'h2, OP_LS = 4'h3, OP_DC = 4'h4;
  localparam logic [69:0] RST_V = {5'b0, 1'b0, 12'h0, 16'h0, 16'h0, 4'h1, 16'h0};
  logic clk = 0, rst = 0, run = 0, fifo_r_accept = 0, ld_done = 0, conv_done = 0;
  logic [31:0] fifo_inst = '0;
  logic fifo_r_en, ld_start, ld_sel, conv_start, busy, err;
  logic [11:0] ld_addr;
  logic [15:0] ld_len, conv_out_addr, inst_count;
  logic [3:0] conv_stride;
  inst_dispatch dut (
    .clk(clk), .rst(rst), .run(run),
    .fifo_r_en(fifo_r_en), .fifo_r_accept(fifo_r_accept), .fifo_inst(fifo_inst),
    .ld_start(ld_start), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done),
    .conv_start(conv_start), .conv_stride(conv_stride), .conv_out_addr(conv_out_addr), .conv_done(conv_done),
    .busy(busy), .inst_count(inst_count), .err(err)
  );
  always #5 clk = ~clk;
  int applied = 0, miscompares = 0, cyc_n = 0;
  logic [31:0] q[$];
  logic [15:0] m_count = 0;
  logic [3:0] m_stride = 4'd1;
  logic m_err = 0;
  logic [28:0] m_ld[$];
  logic [19:0] m_dc[$];
  int ld_cnt = -1, conv_cnt = -1, ld_dly = -1, conv_dly = -1;
  bit coinc = 0, rnd_run = 0, fetch_seen = 0, idle_seen = 0;
  int n_ld_start = 0, n_conv_start = 0, last_start = 0, first_fetch_after = 0;

  task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
    applied++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [69:0] outs();
    return {fifo_r_en, ld_start, conv_start, busy, err, ld_sel, ld_addr, ld_len, conv_out_addr, conv_stride, inst_count};
  endfunction

  function automatic void model_apply(logic [31:0] i);
    logic [3:0] op = i[31:28];
    if (op == OP_LF || op == OP_LI) m_ld.push_back({op == OP_LI, i[27:16], i[15:0]});
    else if (op == OP_DC) m_dc.push_back({m_stride, i[15:0]});
    else if (op == OP_LS && i[3:0] != 4'h0) m_stride = i[3:0];
    else m_err = 1'b1;
    m_count = m_count + 16'd1;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    int s = $urandom_range(0, 9);
    r[31:28] = s < 2 ? OP_LF : s < 4 ? OP_LI : s < 6 ? OP_LS : s < 8 ? OP_DC : s == 8 ? 4'($urandom_range(5, 15)) : 4'h0;
    return r;
  endfunction

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    fifo_r_accept = 0;
    fifo_inst = $urandom;
    ld_done = 0;
    conv_done = 0;
    if (rnd_run) run = $urandom_range(0, 7) != 0;
    if (!busy) idle_seen = 1;
    if (fifo_r_en) fetch_seen = 1;
    if (fifo_r_en && q.size() > 0 && $urandom_range(0, 3) != 0) begin
      chk("engines_idle_at_fetch", 70'(ld_cnt != -1 || conv_cnt != -1), 70'(0));
      chk("count_at_fetch", 70'(inst_count), 70'(m_count));
      chk("stride_at_fetch", 70'(conv_stride), 70'(m_stride));
      chk("err_at_fetch", 70'(err), 70'(m_err));
      fifo_r_accept = 1;
      fifo_inst = q.pop_front();
      model_apply(fifo_inst);
    end
    if (ld_start || conv_start) begin
      last_start = cyc_n;
      first_fetch_after = 0;
    end else if (fifo_r_en && first_fetch_after == 0) first_fetch_after = cyc_n;
    if (ld_start) begin
      n_ld_start++;
      chk("ld_start_expected", 70'(ld_start), 70'(m_ld.size() != 0));
      if (m_ld.size() != 0) chk("ld_fields", 70'({ld_sel, ld_addr, ld_len}), 70'(m_ld.pop_front()));
      chk("count_at_ld_start", 70'(inst_count), 70'(m_count - 16'd1));
      ld_cnt = ld_dly >= 0 ? ld_dly : $urandom_range(0, 4);
      ld_done = coinc || $urandom_range(0, 3) == 0;
    end else if (ld_cnt == 0) begin
      ld_done = 1;
      ld_cnt = -1;
    end else if (ld_cnt > 0) ld_cnt--;
    else ld_done = $urandom_range(0, 7) == 0;
    if (conv_start) begin
      n_conv_start++;
      chk("conv_start_expected", 70'(conv_start), 70'(m_dc.size() != 0));
      if (m_dc.size() != 0) chk("conv_fields", 70'({conv_stride, conv_out_addr}), 70'(m_dc.pop_front()));
      chk("count_at_conv_start", 70'(inst_count), 70'(m_count - 16'd1));
      conv_cnt = conv_dly >= 0 ? conv_dly : $urandom_range(0, 4);
      conv_done = coinc || $urandom_range(0, 3) == 0;
    end else if (conv_cnt == 0) begin
      conv_done = 1;
      conv_cnt = -1;
    end else if (conv_cnt > 0) conv_cnt--;
    else conv_done = $urandom_range(0, 7) == 0;
  endtask

  task automatic drain(int lim);
    int k = 0;
    while (!(q.size() == 0 && !fifo_r_accept && ld_cnt < 0 && conv_cnt < 0 && (fifo_r_en || !busy)) && k < lim) begin
      cyc();
      k++;
    end
    chk("drain_in_time", 70'(k < lim), 70'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n0;
    rst = 1;
    #1;
    chk("reset_values", outs(), RST_V);
    repeat (2) @(negedge clk);
    rst = 0;
    q.push_back({OP_LS, 24'h0, 4'd2});
    run = 1;
    k = 0;
    do begin cyc(); k++; end while (!fifo_r_accept && k < 50);
    chk("ls_accepted", 70'(fifo_r_accept), 70'(1));
    cyc();
    chk("ls_not_yet_retired", 70'({conv_stride, inst_count}), 70'({4'd1, 16'd0}));
    cyc();
    chk("ls_retired_lat2", 70'({conv_stride, inst_count}), 70'({4'd2, 16'd1}));
    chk("ls_no_starts", 70'(n_ld_start + n_conv_start), 70'(0));
    q.push_back({OP_LI, 12'h123, 16'h0040});
    ld_dly = 4;
    idle_seen = 0;
    drain(100);
    chk("li_fields", 70'({ld_sel, ld_addr, ld_len}), 70'({1'b1, 12'h123, 16'h0040}));
    chk("li_one_pulse", 70'(n_ld_start), 70'(1));
    chk("li_count", 70'(inst_count), 70'(16'd2));
    chk("li_busy_held", 70'(idle_seen), 70'(0));
    chk("li_retire_lat", 70'(first_fetch_after - last_start), 70'(6));
    q.push_back({OP_DC, 12'h0, 16'hBEEF});
    conv_dly = 2;
    coinc = 1;
    drain(100);
    coinc = 0;
    chk("dc_retire_on_second_done", 70'(first_fetch_after - last_start), 70'(4));
    chk("dc_count", 70'(inst_count), 70'(16'd3));
    chk("dc_out_addr", 70'(conv_out_addr), 70'(16'hBEEF));
    q.push_back({OP_LS, 28'h0});
    drain(100);
    chk("ls0_err_stride_count", 70'({err, conv_stride, inst_count}), 70'({1'b1, 4'd2, 16'd4}));
    q.push_back({OP_LS, 24'h0, 4'd5});
    drain(100);
    chk("err_sticky", 70'({err, conv_stride, inst_count}), 70'({1'b1, 4'd5, 16'd5}));
    q.push_back({OP_DC, 12'h0, 16'h0777});
    q.push_back({OP_LS, 24'h0, 4'd3});
    q.push_back({OP_LS, 24'h0, 4'd4});
    conv_dly = 6;
    n0 = n_conv_start;
    k = 0;
    while (n_conv_start == n0 && k < 100) begin cyc(); k++; end
    run = 0;
    fetch_seen = 0;
    k = 0;
    do begin cyc(); k++; end while (busy && k < 50);
    chk("stop_idle", 70'(busy), 70'(0));
    chk("stop_no_fetch", 70'(fetch_seen), 70'(0));
    chk("stop_queue_untouched", 70'(q.size()), 70'(2));
    chk("stop_count", 70'(inst_count), 70'(16'd6));
    run = 1;
    drain(100);
    chk("resume_count_stride", 70'({conv_stride, inst_count}), 70'({4'd4, 16'd8}));
    conv_dly = -1;
    q.push_back({OP_LF, 12'hABC, 16'h0010});
    ld_dly = 5;
    n0 = n_ld_start;
    k = 0;
    while (n_ld_start == n0 && k < 100) begin cyc(); k++; end
    cyc();
    cyc();
    #2;
    rst = 1;
    #1;
    chk("async_reset_mid_load", outs(), RST_V);
    m_count = 0;
    m_stride = 4'd1;
    m_err = 0;
    m_ld.delete();
    m_dc.delete();
    run = 0;
    repeat (3) cyc();
    rst = 0;
    n_ld_start = 0;
    n_conv_start = 0;
    repeat (10) cyc();
    chk("post_reset_count", 70'(inst_count), 70'(0));
    chk("post_reset_idle", 70'(busy), 70'(0));
    chk("post_reset_no_start", 70'(n_ld_start + n_conv_start), 70'(0));
    chk("post_reset_ld_addr", 70'(ld_addr), 70'(0));
    ld_dly = -1;
    run = 1;
    rnd_run = 1;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 20; i++) q.push_back(rand_inst());
      drain(2000);
    end
    rnd_run = 0;
    run = 1;
    drain(200);
    chk("final_count", 70'(inst_count), 70'(m_count));
    chk("final_stride", 70'(conv_stride), 70'(m_stride));
    chk("final_err", 70'(err), 70'(m_err));
    chk("final_loads_issued", 70'(m_ld.size()), 70'(0));
    chk("final_convs_issued", 70'(m_dc.size()), 70'(0));
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
